// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives imem address,
// and loads the IF/ID register under stall/flush/redirect/halt.
module if_stage #(
    parameter int               XLEN       = 32,
    parameter logic [XLEN-1:0]  RESET_PC   = '0,
    parameter int               PC_STEP    = 4,
    parameter logic [XLEN-1:0]  HALT_INSTR = '1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            if_id_valid_o,
    output logic [XLEN-1:0] if_id_pc_o,
    output logic [XLEN-1:0] if_id_pc_next_o,
    output logic [XLEN-1:0] if_id_instr_o,
    output logic            halted_o,
    output logic [31:0]     fetch_count_o
);

    localparam logic [XLEN-1:0] STEP  = XLEN'(PC_STEP);
    localparam logic [XLEN-1:0] AMASK = ~XLEN'(3);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_next;
        logic [XLEN-1:0] instr;
    } if_id_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    if_id_t          ifid_q, ifid_d;
    logic [31:0]     cnt_q, cnt_d;

    logic            in_boot, in_run, in_halt;
    logic            do_redir, do_fetch, do_hold, do_bubble;
    logic            run_ok, halt_ok, is_halt;
    logic [XLEN-1:0] target, pc_inc;

    assign in_boot = (state_q == BOOT);
    assign in_run  = (state_q == RUN);
    assign in_halt = (state_q == HALT);
    assign run_ok  = in_run & ~redirect_valid_i;
    assign halt_ok = in_halt & ~redirect_valid_i;
    assign is_halt = (imem_rdata_i == HALT_INSTR);
    assign target  = redirect_pc_i & AMASK;
    assign pc_inc  = pc_q + STEP;

    // Mutually exclusive actions; redirect outranks stall and flush.
    assign do_redir  = (in_run | in_halt) & redirect_valid_i;
    assign do_fetch  = run_ok & ~stall_i & ~flush_i;
    assign do_hold   = (run_ok & stall_i & ~flush_i)
                     | (halt_ok & stall_i);
    assign do_bubble = (run_ok & flush_i)
                     | (halt_ok & ~stall_i);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= BOOT;
        else     state_q <= state_d;
    end

    // Next-state logic: one boot cycle, then run until a halt word.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (do_fetch && is_halt) state_d = HALT;
            HALT:    if (do_redir) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // FSM outputs.
    always_comb begin
        halted_o = in_halt;
    end

    // Next PC, IF/ID and counter values for the selected action.
    always_comb begin
        pc_d   = pc_q;
        ifid_d = ifid_q;
        cnt_d  = cnt_q;
        unique case (1'b1)
            in_boot: begin
                ifid_d.valid = 1'b0;
            end
            do_redir: begin
                pc_d         = target;
                ifid_d.valid = 1'b0;
            end
            do_fetch: begin
                ifid_d.valid   = 1'b1;
                ifid_d.pc      = pc_q;
                ifid_d.pc_next = pc_inc;
                ifid_d.instr   = imem_rdata_i;
                cnt_d          = cnt_q + 32'd1;
                if (!is_halt) pc_d = pc_inc;
            end
            do_hold: begin
                ifid_d = ifid_q;
            end
            do_bubble: begin
                ifid_d.valid = 1'b0;
            end
            default: begin
                ifid_d = ifid_q;
            end
        endcase
    end

    // PC, IF/ID register and fetch counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            ifid_q <= '0;
            cnt_q  <= '0;
        end else begin
            pc_q   <= pc_d;
            ifid_q <= ifid_d;
            cnt_q  <= cnt_d;
        end
    end

    assign imem_addr_o     = pc_q;
    assign if_id_valid_o   = ifid_q.valid;
    assign if_id_pc_o      = ifid_q.pc;
    assign if_id_pc_next_o = ifid_q.pc_next;
    assign if_id_instr_o   = ifid_q.instr;
    assign fetch_count_o   = cnt_q;

endmodule
